// File: rtl/ball_motion.sv
// ball_motion: per-frame 3D ball kinematics for the pong field.
// The ball is advanced once per frame_clk rising edge. It bounces off the side walls,
// the top and bottom walls and the far wall. At the near plane it is resolved as a
// hit or a miss against the player paddle.
// Handshake: there is no valid/ready pair. A frame tick is the only event. Ball
// outputs and game_state change together on the edge that consumes the tick.
// hit and miss are high for exactly the one cycle after that edge.
module ball_motion #(
  parameter int FIELD_W     = 640,
  parameter int FIELD_H     = 480,
  parameter int BALL_SIZE   = 16,
  parameter int PADDLE_W    = 200,
  parameter int PADDLE_H    = 150,
  parameter int Z_MAX       = 255,
  parameter int VX0         = 2,
  parameter int VY0         = 1,
  parameter int VZ0         = 3,
  parameter int MISS_FRAMES = 60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       serve,
  input  logic [9:0] paddleX,
  input  logic [9:0] paddleY,
  output logic [9:0] ballX,
  output logic [9:0] ballY,
  output logic [7:0] ballZ,
  output logic [1:0] game_state,
  output logic       hit,
  output logic       miss,
  output logic [7:0] hit_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_MISS = 2'b10
  } state_t;

  localparam logic [9:0]        X_CTR  = 10'((FIELD_W - BALL_SIZE) / 2);
  localparam logic [9:0]        Y_CTR  = 10'((FIELD_H - BALL_SIZE) / 2);
  localparam logic signed [10:0] X_LIM = 11'(FIELD_W - BALL_SIZE);
  localparam logic signed [10:0] Y_LIM = 11'(FIELD_H - BALL_SIZE);
  localparam logic signed [10:0] Z_LIM = 11'(Z_MAX);
  localparam logic [10:0]       HALF   = 11'(BALL_SIZE / 2);
  localparam logic [10:0]       PW     = 11'(PADDLE_W);
  localparam logic [10:0]       PH     = 11'(PADDLE_H);
  localparam logic [7:0]        MISS_N = 8'(MISS_FRAMES);

  // Synchroniser and edge detector for the asynchronous frame strobe
  logic s1_q, s2_q, p_q;
  logic tick;

  state_t            state_q, state_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic [7:0]        z_q, z_d;
  logic signed [3:0] vx_q, vx_d, vy_q, vy_d, vz_q, vz_d;
  logic              hit_q, hit_d, miss_q, miss_d;
  logic [7:0]        hc_q, hc_d;
  logic              pend_q, pend_d;
  logic [7:0]        mcnt_q, mcnt_d;

  logic signed [10:0] nx, ny, nz;
  logic [10:0]        cx, cy;
  logic               on_paddle;

  function automatic logic signed [3:0] abs4(input logic signed [3:0] v);
    return v[3] ? -v : v;
  endfunction

  assign tick = s2_q & ~p_q;

  // Two-flop synchroniser plus delay flop. All three load 1 in reset so a high
  // frame_clk cannot produce a tick after release.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      p_q  <= 1'b1;
    end else begin
      s1_q <= frame_clk;
      s2_q <= s1_q;
      p_q  <= s2_q;
    end
  end

  // Candidate positions for this frame, in 11-bit signed so wall overshoot is visible
  always_comb begin
    nx = $signed({1'b0, x_q}) + $signed({{7{vx_q[3]}}, vx_q});
    ny = $signed({1'b0, y_q}) + $signed({{7{vy_q[3]}}, vy_q});
    nz = $signed({3'b000, z_q}) + $signed({{7{vz_q[3]}}, vz_q});
  end

  // Next-state and datapath: serve handling, wall reflection, near-plane resolution
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    vx_d      = vx_q;
    vy_d      = vy_q;
    vz_d      = vz_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    hc_d      = hc_q;
    pend_d    = pend_q;
    mcnt_d    = mcnt_q;
    cx        = '0;
    cy        = '0;
    on_paddle = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (tick && pend_q) begin
          vx_d    = 4'(VX0);
          vy_d    = 4'(VY0);
          vz_d    = 4'(VZ0);
          pend_d  = 1'b0;
          state_d = ST_PLAY;
        end else if (serve) begin
          pend_d = 1'b1;
        end
      end

      ST_PLAY: begin
        if (tick) begin
          if (nx <= 11'sd0) begin
            x_d  = '0;
            vx_d = abs4(vx_q);
          end else if (nx >= X_LIM) begin
            x_d  = X_LIM[9:0];
            vx_d = -abs4(vx_q);
          end else begin
            x_d = nx[9:0];
          end

          if (ny <= 11'sd0) begin
            y_d  = '0;
            vy_d = abs4(vy_q);
          end else if (ny >= Y_LIM) begin
            y_d  = Y_LIM[9:0];
            vy_d = -abs4(vy_q);
          end else begin
            y_d = ny[9:0];
          end

          // Paddle test uses the ball centre after this frame's wall clamping
          cx = {1'b0, x_d} + HALF;
          cy = {1'b0, y_d} + HALF;
          on_paddle = (cx >= {1'b0, paddleX}) && (cx < ({1'b0, paddleX} + PW)) &&
                      (cy >= {1'b0, paddleY}) && (cy < ({1'b0, paddleY} + PH));

          if (nz >= Z_LIM) begin
            z_d  = Z_LIM[7:0];
            vz_d = -abs4(vz_q);
          end else if (nz <= 11'sd0) begin
            z_d = '0;
            if (on_paddle) begin
              vz_d  = abs4(vz_q);
              hit_d = 1'b1;
              if (hc_q != 8'hFF) hc_d = hc_q + 8'd1;
            end else begin
              miss_d  = 1'b1;
              mcnt_d  = '0;
              state_d = ST_MISS;
            end
          end else begin
            z_d = nz[7:0];
          end
        end
      end

      ST_MISS: begin
        if (tick) begin
          mcnt_d = mcnt_q + 8'd1;
          if (mcnt_q + 8'd1 == MISS_N) begin
            x_d     = X_CTR;
            y_d     = Y_CTR;
            z_d     = '0;
            vx_d    = '0;
            vy_d    = '0;
            vz_d    = '0;
            pend_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      x_q     <= X_CTR;
      y_q     <= Y_CTR;
      z_q     <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      vz_q    <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      hc_q    <= '0;
      pend_q  <= 1'b0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vz_q    <= vz_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      hc_q    <= hc_d;
      pend_q  <= pend_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign ballX      = x_q;
  assign ballY      = y_q;
  assign ballZ      = z_q;
  assign game_state = state_q;
  assign hit        = hit_q;
  assign miss       = miss_q;
  assign hit_count  = hc_q;

endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: directed frames with hand-computed ball positions.
// The driver queues the expected outcome of each frame before raising frame_clk.
// The monitor pops an entry on every frame_clk rise and checks the outputs 3 Clk
// edges later.
module tb_ball_motion;

  typedef struct packed {
    logic       chk;
    logic       pre;
    logic [7:0] pre_z;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] z;
    logic [1:0] st;
    logic       hit;
    logic       miss;
    logic [7:0] hc;
  } exp_t;

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic       serve;
  logic [9:0] paddleX, paddleY;
  logic [9:0] ballX, ballY;
  logic [7:0] ballZ;
  logic [1:0] game_state;
  logic       hit, miss;
  logic [7:0] hit_count;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  ball_motion dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .serve      (serve),
    .paddleX    (paddleX),
    .paddleY    (paddleY),
    .ballX      (ballX),
    .ballY      (ballY),
    .ballZ      (ballZ),
    .game_state (game_state),
    .hit        (hit),
    .miss       (miss),
    .hit_count  (hit_count)
  );

  // Clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int x, input int y, input int z, input int st,
                              input int h, input int m, input int hc);
    exp_t e;
    e       = '0;
    e.chk   = 1'b1;
    e.x     = 10'(x);
    e.y     = 10'(y);
    e.z     = 8'(z);
    e.st    = 2'(st);
    e.hit   = 1'(h);
    e.miss  = 1'(m);
    e.hc    = 8'(hc);
    return e;
  endfunction

  // Driver: one frame_clk period of 8 Clk cycles, expected outcome queued first
  task automatic frame(input exp_t e);
    exp_q.push_back(e);
    @(negedge Clk) frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) frame('0);
  endtask

  task automatic pulse_serve();
    @(negedge Clk) serve = 1'b1;
    @(negedge Clk) serve = 1'b0;
  endtask

  task automatic check_centre_idle(input string tag);
    check({tag, "_x"}, ballX, 312);
    check({tag, "_y"}, ballY, 232);
    check({tag, "_z"}, ballZ, 0);
    check({tag, "_state"}, game_state, 0);
    check({tag, "_hc"}, hit_count, 0);
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge frame_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        @(posedge Clk);
        @(posedge Clk);
        #1;
        if (e.pre) check("z_before_update", ballZ, e.pre_z);
        @(posedge Clk);
        #1;
        if (e.chk) begin
          check("ballX", ballX, e.x);
          check("ballY", ballY, e.y);
          check("ballZ", ballZ, e.z);
          check("game_state", game_state, e.st);
          check("hit", hit, e.hit);
          check("miss", miss, e.miss);
          check("hit_count", hit_count, e.hc);
          @(posedge Clk);
          #1;
          check("hit_pulse_end", hit, 0);
          check("miss_pulse_end", miss, 0);
        end
      end
    end
  end

  // Stimulus
  initial begin : driver
    exp_t e;
    Reset     = 1'b0;
    frame_clk = 1'b1;
    serve     = 1'b0;
    paddleX   = 10'd439;
    paddleY   = 10'd329;

    // Reset held 5 Clk with frame_clk high
    repeat (5) @(negedge Clk);
    check_centre_idle("reset");
    check("reset_hit", hit, 0);
    check("reset_miss", miss, 0);

    // Release with a serve pending; frame_clk still high must not create a tick
    Reset = 1'b1;
    serve = 1'b1;
    @(negedge Clk) serve = 1'b0;
    repeat (5) @(negedge Clk);
    check("no_tick_after_reset", game_state, 0);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);

    // Hit run
    frame(mk(312, 232, 0, 1, 0, 0, 0));          // serve tick
    e = mk(314, 233, 3, 1, 0, 0, 0);
    e.pre = 1'b1;
    e.pre_z = 8'd0;
    frame(e);                                      // move 1
    skip(83);                                      // moves 2..84
    frame(mk(482, 317, 255, 1, 0, 0, 0));         // move 85: far wall
    frame(mk(484, 318, 252, 1, 0, 0, 0));         // move 86
    skip(69);                                      // moves 87..155
    frame(mk(624, 388, 42, 1, 0, 0, 0));          // move 156: right wall
    frame(mk(622, 389, 39, 1, 0, 0, 0));          // move 157
    skip(12);                                      // moves 158..169
    frame(mk(596, 402, 0, 1, 1, 0, 1));           // move 170: hit
    frame(mk(594, 403, 3, 1, 0, 0, 1));           // move 171

    // Reset mid-play
    @(negedge Clk) Reset = 1'b0;
    @(posedge Clk);
    #1;
    check_centre_idle("reset_play");
    @(negedge Clk) Reset = 1'b1;

    // Miss run
    paddleX = 10'd220;
    paddleY = 10'd165;
    pulse_serve();
    frame(mk(312, 232, 0, 1, 0, 0, 0));
    skip(169);
    frame(mk(596, 402, 0, 2, 0, 1, 0));           // move 170: miss
    pulse_serve();                                 // ignored in MISS
    skip(58);
    frame(mk(596, 402, 0, 2, 0, 0, 0));           // 59th hold tick: frozen
    frame(mk(312, 232, 0, 0, 0, 0, 0));           // 60th: back to IDLE
    frame(mk(312, 232, 0, 0, 0, 0, 0));           // serve during MISS was dropped

    // Second miss, then reset mid-MISS
    pulse_serve();
    frame(mk(312, 232, 0, 1, 0, 0, 0));
    skip(169);
    frame(mk(596, 402, 0, 2, 0, 1, 0));
    skip(9);
    @(negedge Clk) Reset = 1'b0;
    @(posedge Clk);
    #1;
    check_centre_idle("reset_miss");
    @(negedge Clk) Reset = 1'b1;

    repeat (20) @(negedge Clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_motion.md
# ball_motion

Per-frame 3D ball kinematics and paddle collision for the pong field. The block consumes the paddle position produced by the paddle movement stage (`paddleX`/`paddleY`, updated once per frame) and the VGA `frame_clk`. It advances the ball in X, Y and depth Z once per frame, reflects the ball off the field walls and the far wall, and resolves hit or miss at the near (player) plane. Its outputs drive the ball renderer and the score logic.

## Interface
- FIELD_W, 640, field width in pixels
- FIELD_H, 480, field height in pixels
- BALL_SIZE, 16, ball sprite edge in pixels
- PADDLE_W, 200, paddle width in pixels
- PADDLE_H, 150, paddle height in pixels
- Z_MAX, 255, far-wall depth
- VX0 / VY0 / VZ0, 2 / 1 / 3, serve velocities; signed, magnitude 1..7
- MISS_FRAMES, 60, frames the ball is held after a miss

- Clk  in  1  system clock; the only clock
- Reset  in  1  synchronous, active-low reset
- frame_clk  in  1  VGA frame strobe, asynchronous to Clk; its rising edge means one frame
- serve  in  1  serve request, any width pulse
- paddleX  in  10  paddle left edge, 0..FIELD_W-PADDLE_W-1
- paddleY  in  10  paddle top edge, 0..FIELD_H-PADDLE_H-1
- ballX, ballY  out  10  ball top-left corner
- ballZ  out  8  ball depth; 0 is the near plane
- game_state  out  2  00 IDLE, 01 PLAY, 10 MISS
- hit, miss  out  1  one-Clk pulses
- hit_count  out  8  hits since reset, saturating

## Operation
- **frame_clk synchroniser:** frame_clk passes through two flops (s1, s2) and a delay flop (p). tick = s2 & ~p.
- **Reset (Reset=0 at a Clk edge):**
  - s1, s2 and p load 1, so no spurious tick follows reset.
  - state = IDLE; ball = centre (X = (FIELD_W-BALL_SIZE)/2 = 312, Y = (FIELD_H-BALL_SIZE)/2 = 232, Z = 0).
  - Velocity = 0; hit, miss and hit_count = 0; serve_pending = 0.
  - Reset applies mid-frame and mid-MISS.
- **IDLE:**
  - serve=1 on any Clk sets serve_pending.
  - On tick with serve_pending: velocity = (VX0, VY0, +VZ0), state = PLAY, serve_pending = 0. Position is unchanged on that tick.
  - serve is ignored outside IDLE.
- **PLAY, on each tick:**
  - Compute nx = X+VX, ny = Y+VY and nz = Z+VZ in 11-bit signed.
  - X walls:
    - nx ≤ 0 → X = 0, VX = +|VX|.
    - nx ≥ FIELD_W-BALL_SIZE (624) → X = 624, VX = −|VX|.
    - Otherwise X = nx.
  - Y walls: same rule with limits 0 and 464.
  - Far wall: nz ≥ Z_MAX → Z = Z_MAX, VZ = −|VZ|.
  - Near plane, nz ≤ 0:
    - Take the ball centre cx = X'+BALL_SIZE/2 and cy = Y'+BALL_SIZE/2, using the post-wall X' and Y'.
    - Hit iff paddleX ≤ cx < paddleX+PADDLE_W and paddleY ≤ cy < paddleY+PADDLE_H. Compare in 11-bit unsigned.
    - Hit → Z = 0, VZ = +|VZ|, hit pulse, hit_count+1 (saturates at 255).
    - Miss → Z = 0, miss pulse, state = MISS, miss counter = 0.
  - Otherwise Z = nz.
  - Wall reflections and the near-plane decision all apply in the same tick.
- **MISS:**
  - The ball is frozen.
  - Each tick increments the miss counter.
  - On the tick where the counter reaches MISS_FRAMES: ball = centre, velocity = 0, state = IDLE. serve_pending starts clear, so a serve made during MISS is ignored.
- **Paddle inputs:** sampled only on the tick cycle and treated as stable then.

## Timing
- frame_clk first sampled high at Clk edge k:
  - s1 at k, s2 at k+1, tick high in cycle k+1..k+2.
  - ball, state, hit and miss update at edge k+2.
- Latency from frame_clk edge to outputs: 3 Clk edges. One update per frame_clk rising edge.
- frame_clk high and low phases must each last ≥ 3 Clk periods.
- hit and miss are registered, high for exactly the one cycle after the updating edge, and are never both high.
- game_state changes on the same edge as the ball outputs.
- serve to PLAY: takes effect on the first tick at least 1 Clk after serve is sampled.

## Test plan
- **Reset:** hold Reset=0 for 5 Clk with frame_clk high → X=312, Y=232, Z=0, game_state=00, hit_count=0, and no tick after release.
- **Serve:** pulse serve for 1 Clk, then 2 frames → PLAY after frame 1, with X=312, Y=232, Z=0. After frame 2: X=314, Y=233, Z=3, exactly 3 Clk after the frame_clk edge.
- **Far wall:** 85 frames after serve → Z=255, VZ becomes −3. Next frame Z=252.
- **X wall:** frame 156 after serve → X=624, VX=−2. Frame 157 → X=622.
- **Hit:** paddleX=439, paddleY=329; at frame 170 → X=596, Y=402, Z=0, hit=1 for 1 Clk, hit_count=1. Frame 171 → Z=3.
- **Miss:** paddle at 220,165; at frame 170 → miss=1, game_state=10, ball frozen. 60 frames later → IDLE at centre. A serve issued during MISS is ignored. Reset asserted mid-MISS → IDLE at centre on the next Clk.
